// File: rtl/uart11_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart11_mux (with helper uart11_mux_fifo)                      |
// | Description : NCHAN-channel DL11-style UART register block. Each channel    |
// |               has a TX and an RX single-clock FIFO. The PDP-11 bus side     |
// |               sees RCSR/RBUF/XCSR/XBUF per channel, and the 32-bit host     |
// |               side pops TX data, pushes RX data, reads status and issues    |
// |               flush/flag-clear controls. Per-channel RX/TX interrupts are   |
// |               registered and level-sensitive.                               |
// | Ports       : clk, busrst_n (async active-low reset)                        |
// |               uartreq/uartaddr/uartwr/uartwdata -> uartack/uartrdata        |
// |               uarthostreq/uarthostaddr/uarthostwr/uarthostwdata             |
// |                 -> uarthostack/uarthostrdata                                |
// |               uartirq[2c] RX irq, uartirq[2c+1] TX irq of channel c         |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+

module uart11_mux_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             busrst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [AW:0]      count,
    output logic [WIDTH-1:0] head,
    output logic             nonempty,
    output logic             notfull,
    output logic             pop_ok
);
    logic [AW:0]      cnt_q, cnt_d;
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic             push_ok;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign nonempty = (cnt_q != '0);
    assign notfull  = (cnt_q != (AW+1)'(DEPTH));
    assign count    = cnt_q;
    assign head     = mem_q[rp_q];

    // Acceptance is judged on the occupancy at the start of the cycle, so a
    // pop never makes room for a push in the same cycle, and a push into an
    // empty FIFO is never visible to a same-cycle pop.
    always_comb begin
        push_ok = push && notfull && !flush;
        pop_ok  = pop && nonempty;
        cnt_d   = cnt_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        if (flush) begin
            cnt_d = '0;
            wp_d  = '0;
            rp_d  = '0;
        end else begin
            if (push_ok) wp_d = wp_q + AW'(1);
            if (pop_ok)  rp_d = rp_q + AW'(1);
            cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge busrst_n) begin
        if (!busrst_n) begin
            cnt_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wp_q] <= wdata;
    end
endmodule

module uart11_mux #(
    parameter  int NCHAN = 4,
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int CW    = (NCHAN > 1) ? $clog2(NCHAN) : 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               busrst_n,
    input  logic               uartreq,
    input  logic [2+CW:0]      uartaddr,
    input  logic               uartwr,
    input  logic [15:0]        uartwdata,
    output logic               uartack,
    output logic [15:0]        uartrdata,
    output logic [2*NCHAN-1:0] uartirq,
    input  logic               uarthostreq,
    input  logic [1+CW:0]      uarthostaddr,
    input  logic               uarthostwr,
    input  logic [31:0]        uarthostwdata,
    output logic               uarthostack,
    output logic [31:0]        uarthostrdata
);
    logic [CW-1:0] bus_ch, host_ch;
    logic [1:0]    bus_reg, host_reg;
    wire  [15:0]   bus_rd_w  [NCHAN];
    wire  [31:0]   host_rd_w [NCHAN];
    wire  [2*NCHAN-1:0] irq_w;

    logic               ack_q, ack_d, hostack_q, hostack_d;
    logic [15:0]        rdata_q, rdata_d;
    logic [31:0]        hostrdata_q, hostrdata_d;
    logic [2*NCHAN-1:0] irq_q, irq_d;
    logic               unused_ok;

    assign bus_ch    = uartaddr[2+CW:3];
    assign bus_reg   = uartaddr[2:1];
    assign host_ch   = uarthostaddr[1+CW:2];
    assign host_reg  = uarthostaddr[1:0];
    assign unused_ok = ^{uartaddr[0], uartwdata, uarthostwdata};

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        logic             bus_hit, host_hit;
        logic             tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush, flag_clr;
        logic             rxie_q, rxie_d, txie_q, txie_d, ovr_q, ovr_d, err_q, err_d;
        logic [AW:0]      tx_count, rx_count;
        logic [WIDTH-1:0] tx_head, rx_head;
        logic             tx_ne, tx_nf, rx_ne, rx_nf, tx_pop_ok, rx_pop_ok;
        logic             unused_rx_pop_ok;
        logic [15:0]      bus_rd;
        logic [31:0]      host_rd;

        always_comb begin
            bus_hit  = uartreq && (bus_ch == CW'(c));
            host_hit = uarthostreq && (host_ch == CW'(c));
            tx_push  = bus_hit && uartwr && (bus_reg == 2'd3);
            rx_pop   = bus_hit && !uartwr && (bus_reg == 2'd1);
            tx_pop   = host_hit && !uarthostwr && (host_reg == 2'd0);
            rx_push  = host_hit && uarthostwr && (host_reg == 2'd0);
            tx_flush = host_hit && uarthostwr && (host_reg == 2'd1) && uarthostwdata[0];
            rx_flush = host_hit && uarthostwr && (host_reg == 2'd1) && uarthostwdata[1];
            flag_clr = host_hit && uarthostwr && (host_reg == 2'd1) && uarthostwdata[2];
        end

        uart11_mux_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_tx (
            .clk(clk), .busrst_n(busrst_n), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
            .wdata(uartwdata[WIDTH-1:0]), .count(tx_count), .head(tx_head),
            .nonempty(tx_ne), .notfull(tx_nf), .pop_ok(tx_pop_ok)
        );

        uart11_mux_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_rx (
            .clk(clk), .busrst_n(busrst_n), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
            .wdata(uarthostwdata[WIDTH-1:0]), .count(rx_count), .head(rx_head),
            .nonempty(rx_ne), .notfull(rx_nf), .pop_ok(rx_pop_ok)
        );
        assign unused_rx_pop_ok = rx_pop_ok;

        // An RBUF read clears the flags, but a host push landing in the same
        // cycle re-arms them so an overrun is never lost.
        always_comb begin
            rxie_d = rxie_q;
            txie_d = txie_q;
            ovr_d  = ovr_q;
            err_d  = err_q;
            if (bus_hit && uartwr && (bus_reg == 2'd0)) rxie_d = uartwdata[6];
            if (bus_hit && uartwr && (bus_reg == 2'd2)) txie_d = uartwdata[6];
            if (rx_pop || flag_clr) begin
                ovr_d = 1'b0;
                err_d = 1'b0;
            end
            if (rx_push && !rx_nf)           ovr_d = 1'b1;
            if (rx_push && uarthostwdata[31]) err_d = 1'b1;
        end

        always_ff @(posedge clk or negedge busrst_n) begin
            if (!busrst_n) begin
                rxie_q <= 1'b0;
                txie_q <= 1'b0;
                ovr_q  <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                rxie_q <= rxie_d;
                txie_q <= txie_d;
                ovr_q  <= ovr_d;
                err_q  <= err_d;
            end
        end

        always_comb begin
            bus_rd = '0;
            case (bus_reg)
                2'd0:    bus_rd = {8'd0, rx_ne, rxie_q, 6'd0};
                2'd1:    bus_rd = {err_q, ovr_q, 6'd0, rx_ne ? 8'(rx_head) : 8'd0};
                2'd2:    bus_rd = {8'd0, tx_nf, txie_q, 6'd0};
                default: bus_rd = '0;
            endcase
        end

        always_comb begin
            host_rd = '0;
            case (host_reg)
                2'd0: host_rd = tx_ne ? {1'b1, 7'd0, 8'(tx_count - (AW+1)'(tx_pop_ok)),
                                         8'd0, 8'(tx_head)} : '0;
                2'd1: host_rd = {!rx_nf, !tx_ne, 6'd0, 8'(rx_count), 8'd0, 8'(tx_count)};
                default: host_rd = '0;
            endcase
        end

        assign bus_rd_w[c]  = bus_rd;
        assign host_rd_w[c] = host_rd;
        assign irq_w[2*c]   = rxie_q & rx_ne;
        assign irq_w[2*c+1] = txie_q & tx_nf;
    end

    // Channels at or above NCHAN never match, so their reads stay zero.
    always_comb begin
        ack_d       = uartreq;
        hostack_d   = uarthostreq;
        rdata_d     = '0;
        hostrdata_d = '0;
        irq_d       = irq_w;
        for (int c = 0; c < NCHAN; c++) begin
            if (uartreq && !uartwr && (bus_ch == CW'(c)))             rdata_d     = bus_rd_w[c];
            if (uarthostreq && !uarthostwr && (host_ch == CW'(c)))    hostrdata_d = host_rd_w[c];
        end
    end

    always_ff @(posedge clk or negedge busrst_n) begin
        if (!busrst_n) begin
            ack_q       <= 1'b0;
            hostack_q   <= 1'b0;
            rdata_q     <= '0;
            hostrdata_q <= '0;
            irq_q       <= '0;
        end else begin
            ack_q       <= ack_d;
            hostack_q   <= hostack_d;
            rdata_q     <= rdata_d;
            hostrdata_q <= hostrdata_d;
            irq_q       <= irq_d;
        end
    end

    assign uartack       = ack_q;
    assign uartrdata     = rdata_q;
    assign uarthostack   = hostack_q;
    assign uarthostrdata = hostrdata_q;
    assign uartirq       = irq_q;
endmodule

`default_nettype wire

// File: tb/tb_uart11_mux.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_uart11_mux                                                 |
// | Description : Table-driven bench for uart11_mux (NCHAN=4, DEPTH=16, WIDTH=8)|
// |               with a second NCHAN=3 instance for out-of-range channels.     |
// |               Expected read data is queued when a request is driven and     |
// |               compared when the acknowledge arrives.                        |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_uart11_mux;
    logic        clk = 1'b0;
    logic        busrst_n = 1'b0;
    logic        uartreq = 1'b0, uartwr = 1'b0;
    logic [4:0]  uartaddr = '0;
    logic [15:0] uartwdata = '0;
    logic        uarthostreq = 1'b0, uarthostwr = 1'b0;
    logic [3:0]  uarthostaddr = '0;
    logic [31:0] uarthostwdata = '0;

    wire         uartack, uarthostack, uartack3, uarthostack3;
    wire [15:0]  uartrdata, uartrdata3;
    wire [31:0]  uarthostrdata, uarthostrdata3;
    wire [7:0]   uartirq;
    wire [5:0]   uartirq3;

    always #5 clk = ~clk;

    uart11_mux #(.NCHAN(4), .DEPTH(16), .WIDTH(8)) u_dut (
        .clk(clk), .busrst_n(busrst_n),
        .uartreq(uartreq), .uartaddr(uartaddr), .uartwr(uartwr), .uartwdata(uartwdata),
        .uartack(uartack), .uartrdata(uartrdata), .uartirq(uartirq),
        .uarthostreq(uarthostreq), .uarthostaddr(uarthostaddr), .uarthostwr(uarthostwr),
        .uarthostwdata(uarthostwdata), .uarthostack(uarthostack), .uarthostrdata(uarthostrdata)
    );

    uart11_mux #(.NCHAN(3), .DEPTH(16), .WIDTH(8)) u_dut3 (
        .clk(clk), .busrst_n(busrst_n),
        .uartreq(uartreq), .uartaddr(uartaddr), .uartwr(uartwr), .uartwdata(uartwdata),
        .uartack(uartack3), .uartrdata(uartrdata3), .uartirq(uartirq3),
        .uarthostreq(uarthostreq), .uarthostaddr(uarthostaddr), .uarthostwr(uarthostwr),
        .uarthostwdata(uarthostwdata), .uarthostack(uarthostack3), .uarthostrdata(uarthostrdata3)
    );

    typedef struct {
        bit          b_en;
        bit          b_wr;
        logic [4:0]  b_addr;
        logic [15:0] b_wd;
        logic [15:0] b_exp;
        bit          h_en;
        bit          h_wr;
        logic [3:0]  h_addr;
        logic [31:0] h_wd;
        logic [31:0] h_exp;
    } vec_t;

    typedef struct {
        bit          host;
        bit          chk;
        logic [31:0] exp;
        int          tag;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   tag_cnt = 0;

    task automatic check(input string nm, input int tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s #%0d: got 0x%08h, expected 0x%08h", nm, tag, act, exp);
    endtask

    function automatic vec_t brd(input int ch, input int rg, input logic [15:0] exp);
        vec_t v = '{default: '0};
        v.b_en = 1'b1; v.b_addr = {2'(ch), 2'(rg), 1'b0}; v.b_exp = exp;
        return v;
    endfunction

    function automatic vec_t bwr(input int ch, input int rg, input logic [15:0] wd);
        vec_t v = '{default: '0};
        v.b_en = 1'b1; v.b_wr = 1'b1; v.b_addr = {2'(ch), 2'(rg), 1'b0}; v.b_wd = wd;
        return v;
    endfunction

    function automatic vec_t hrd(input int ch, input int rg, input logic [31:0] exp);
        vec_t v = '{default: '0};
        v.h_en = 1'b1; v.h_addr = {2'(ch), 2'(rg)}; v.h_exp = exp;
        return v;
    endfunction

    function automatic vec_t hwr(input int ch, input int rg, input logic [31:0] wd);
        vec_t v = '{default: '0};
        v.h_en = 1'b1; v.h_wr = 1'b1; v.h_addr = {2'(ch), 2'(rg)}; v.h_wd = wd;
        return v;
    endfunction

    function automatic vec_t both(input vec_t b, input vec_t h);
        vec_t v = b;
        v.h_en = h.h_en; v.h_wr = h.h_wr; v.h_addr = h.h_addr; v.h_wd = h.h_wd; v.h_exp = h.h_exp;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        sb_t e;
        @(posedge clk); #1;
        uartreq = v.b_en; uartwr = v.b_wr; uartaddr = v.b_addr; uartwdata = v.b_wd;
        uarthostreq = v.h_en; uarthostwr = v.h_wr; uarthostaddr = v.h_addr; uarthostwdata = v.h_wd;
        if (v.b_en) begin
            e.host = 1'b0; e.chk = !v.b_wr; e.exp = {16'd0, v.b_exp}; e.tag = tag_cnt;
            sbq.push_back(e);
        end
        if (v.h_en) begin
            e.host = 1'b1; e.chk = !v.h_wr; e.exp = v.h_exp; e.tag = tag_cnt;
            sbq.push_back(e);
        end
        tag_cnt++;
        @(posedge clk); #1;
        uartreq = 1'b0; uarthostreq = 1'b0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.host) begin
                check("host_ack", e.tag, 32'(uarthostack), 32'd1);
                if (e.chk) check("host_rdata", e.tag, uarthostrdata, e.exp);
            end else begin
                check("bus_ack", e.tag, 32'(uartack), 32'd1);
                if (e.chk) check("bus_rdata", e.tag, {16'd0, uartrdata}, e.exp);
            end
        end
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_irq", -1, 32'(uartirq), 32'd0);
        check("rst_ack", -1, 32'(uartack), 32'd0);
        check("rst_hostack", -1, 32'(uarthostack), 32'd0);
        check("rst_rdata", -1, 32'(uartrdata), 32'd0);
        check("rst_hostrdata", -1, uarthostrdata, 32'd0);
        busrst_n = 1'b1;

        // Reset register view of channel 2
        tbl.push_back(brd(2, 0, 16'h0000));
        tbl.push_back(brd(2, 2, 16'h0080));
        tbl.push_back(hrd(2, 1, 32'h4000_0000));
        run_tbl();
        check("irq_idle", -1, 32'(uartirq), 32'd0);

        // TX interrupt and TX FIFO fill on channel 1
        tbl.push_back(bwr(1, 2, 16'h0040));
        run_tbl();
        @(posedge clk); #1;
        check("irq_tx1_set", -1, 32'(uartirq[3]), 32'd1);
        for (int i = 0; i < 16; i++) tbl.push_back(bwr(1, 3, 16'(8'h41 + i)));
        run_tbl();
        @(posedge clk); #1;
        check("irq_tx1_full", -1, 32'(uartirq[3]), 32'd0);
        tbl.push_back(brd(1, 2, 16'h0040));
        tbl.push_back(bwr(1, 3, 16'h0051));
        for (int i = 0; i < 16; i++)
            tbl.push_back(hrd(1, 0, 32'h8000_0000 | 32'((15 - i) << 16) | 32'(8'h41 + i)));
        tbl.push_back(hrd(1, 0, 32'h0000_0000));
        tbl.push_back(hrd(1, 1, 32'h4000_0000));
        run_tbl();

        // RX interrupt timing on channel 0
        tbl.push_back(bwr(0, 0, 16'h0040));
        tbl.push_back(hwr(0, 0, 32'h0000_0055));
        run_tbl();
        check("irq_rx0_pre", -1, 32'(uartirq[0]), 32'd0);
        @(posedge clk); #1;
        check("irq_rx0_rise", -1, 32'(uartirq[0]), 32'd1);
        tbl.push_back(brd(0, 1, 16'h0055));
        run_tbl();
        check("irq_rx0_hold", -1, 32'(uartirq[0]), 32'd1);
        @(posedge clk); #1;
        check("irq_rx0_drop", -1, 32'(uartirq[0]), 32'd0);
        tbl.push_back(hwr(0, 0, 32'h8000_0066));
        tbl.push_back(brd(0, 1, 16'h8066));
        tbl.push_back(brd(0, 1, 16'h0000));
        run_tbl();

        // RX overrun on channel 3
        for (int i = 0; i < 17; i++) tbl.push_back(hwr(3, 0, 32'(8'h30 + i)));
        tbl.push_back(hrd(3, 1, 32'hC010_0000));
        tbl.push_back(brd(3, 1, 16'h4030));
        tbl.push_back(brd(3, 1, 16'h0031));
        tbl.push_back(hwr(3, 0, 32'h0000_0040));
        tbl.push_back(hwr(3, 0, 32'h0000_0041));
        run_tbl();

        // Full RX: same-cycle pop and push; pop wins, push dropped, ovr set
        tbl.push_back(both(brd(3, 1, 16'h0032), hwr(3, 0, 32'h0000_007A)));
        tbl.push_back(hrd(3, 1, 32'h400F_0000));
        tbl.push_back(brd(3, 1, 16'h4033));
        tbl.push_back(hwr(3, 0, 32'h8000_0011));
        tbl.push_back(hwr(3, 1, 32'h0000_0004));
        tbl.push_back(brd(3, 1, 16'h0034));
        run_tbl();

        // Flush with a concurrent XBUF push on channel 2
        tbl.push_back(bwr(2, 3, 16'h0021));
        tbl.push_back(hwr(2, 0, 32'h0000_0022));
        tbl.push_back(hrd(2, 1, 32'h0001_0001));
        tbl.push_back(both(bwr(2, 3, 16'h0023), hwr(2, 1, 32'h0000_0003)));
        tbl.push_back(hrd(2, 1, 32'h4000_0000));
        tbl.push_back(brd(2, 1, 16'h0000));
        run_tbl();

        // Channel 3 does not exist in the NCHAN=3 instance
        @(posedge clk); #1;
        uartreq = 1'b1; uartwr = 1'b0; uartaddr = {2'd3, 2'd2, 1'b0};
        uarthostreq = 1'b1; uarthostwr = 1'b0; uarthostaddr = {2'd3, 2'd1};
        @(posedge clk); #1;
        uartreq = 1'b0; uarthostreq = 1'b0;
        check("oor_bus_ack", -1, 32'(uartack3), 32'd1);
        check("oor_bus_rdata", -1, 32'(uartrdata3), 32'd0);
        check("oor_host_ack", -1, 32'(uarthostack3), 32'd1);
        check("oor_host_rdata", -1, uarthostrdata3, 32'd0);
        check("ch3_xcsr_ref", -1, 32'(uartrdata), 32'h0000_0080);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
